// File: rtl/tinyalu_param.sv
// Parametrised TinyALU: pulse-accepted commands, captured operands, fixed per-op latency.
// MUL completes MUL_LAT cycles after accept, every other op after one cycle.
//   state | meaning
//   IDLE  | waiting for start; busy low
//   EXEC  | command in flight; down-counter reaches 0 on the completion edge
module tinyalu_param #(
    parameter int DATA_W  = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result,
    output logic                  illegal_op
);

    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2:0]          op_q;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] op_res;
    logic                op_ill;

    // Everything is computed from the captured operands, so pin changes after accept are inert.
    always_comb begin
        a_ext  = {{DATA_W{1'b0}}, a_q};
        b_ext  = {{DATA_W{1'b0}}, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        op_res = '0;
        op_ill = 1'b0;
        case (op_q)
            OP_NOP:  op_res = result;
            OP_ADD:  op_res = a_ext + b_ext;
            OP_AND:  op_res = a_ext & b_ext;
            OP_XOR:  op_res = a_ext ^ b_ext;
            OP_MUL:  op_res = a_ext * b_ext;
            OP_SUB:  op_res = {{(DATA_W-1){diff[DATA_W]}}, diff};
            default: op_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
            result     <= '0;
        end else begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        cnt   <= (op == OP_MUL) ? MUL_CNT : '0;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        illegal_op <= op_ill;
                        result     <= op_res;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed bench for tinyalu_param: stimulus pushes expected completions, a monitor pops and compares on done.
module tb_tinyalu_param;
    localparam int DATA_W  = 8;
    localparam int MUL_LAT = 3;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [DATA_W-1:0]   A = '0;
    logic [DATA_W-1:0]   B = '0;
    logic [2:0]          op = '0;
    logic                start = 1'b0;
    logic                busy;
    logic                done;
    logic [2*DATA_W-1:0] result;
    logic                illegal_op;

    tinyalu_param #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
        .busy(busy), .done(done), .result(result), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*DATA_W-1:0] res;
        logic                ill;
        int                  cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",     32'(result),     32'(e.res));
                chk("illegal_op", 32'(illegal_op), 32'(e.ill));
                chk("done_cycle", 32'(cyc),        32'(e.cyc));
            end
        end else if (illegal_op) begin
            chk("illegal_without_done", 32'(illegal_op), 32'd0);
        end
    end

    // Called at a negedge; start is sampled at the next posedge (the accept edge).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input logic [15:0] res, input logic ill, input int lat, input bit push);
        exp_t e;
        A = a; B = b; op = o; start = 1'b1;
        if (push) begin
            e.res = res; e.ill = ill; e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_result", 32'(result),     32'd0);
        chk("rst_ill",    32'(illegal_op), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD carry out of DATA_W, accepted on the first edge after release
        issue(8'hFF, 8'h01, 3'b001, 16'h0100, 1'b0, 1, 1'b1);
        wait_idle();
        chk("add_result_held", 32'(result), 32'h0100);

        // MUL with operand change after accept
        issue(8'hFF, 8'hFF, 3'b100, 16'hFE01, 1'b0, MUL_LAT, 1'b1);
        A = 8'h00; B = 8'h00;
        @(negedge clk);
        chk("mul_busy_k1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("mul_busy_k2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("mul_busy_k3", 32'(busy), 32'd0);
        @(negedge clk);

        issue(8'h03, 8'h05, 3'b101, 16'hFFFE, 1'b0, 1, 1'b1);
        wait_idle();
        issue(8'h05, 8'h03, 3'b101, 16'h0002, 1'b0, 1, 1'b1);
        wait_idle();
        issue(8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 1, 1'b1);
        wait_idle();
        issue(8'hF0, 8'h3C, 3'b011, 16'h00CC, 1'b0, 1, 1'b1);
        wait_idle();

        // Start during busy is ignored; ADD raised in the MUL done cycle is accepted
        issue(8'h02, 8'h03, 3'b100, 16'h0006, 1'b0, MUL_LAT, 1'b1);
        A = 8'h01; B = 8'h01; op = 3'b001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("mul_done_seen", 32'(done), 32'd1);
        issue(8'h10, 8'h20, 3'b001, 16'h0030, 1'b0, 1, 1'b1);
        wait_idle();

        issue(8'h12, 8'h34, 3'b111, 16'h0000, 1'b1, 1, 1'b1);
        wait_idle();
        issue(8'h01, 8'h01, 3'b001, 16'h0002, 1'b0, 1, 1'b1);
        wait_idle();
        issue(8'h77, 8'h66, 3'b000, 16'h0002, 1'b0, 1, 1'b1);
        wait_idle();
        issue(8'h12, 8'h34, 3'b110, 16'h0000, 1'b1, 1, 1'b1);
        wait_idle();
        issue(8'h05, 8'h03, 3'b001, 16'h0008, 1'b0, 1, 1'b1);
        wait_idle();

        // Reset two cycles into a MUL: no completion may follow
        issue(8'h12, 8'h34, 3'b100, 16'h0000, 1'b0, MUL_LAT, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy",   32'(busy),       32'd0);
        chk("midrst_done",   32'(done),       32'd0);
        chk("midrst_result", 32'(result),     32'd0);
        chk("midrst_ill",    32'(illegal_op), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_result", 32'(result), 32'd0);
        issue(8'h02, 8'h03, 3'b001, 16'h0005, 1'b0, 1, 1'b1);
        wait_idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
